// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//
// Multi-cycle controller for a small accumulator-style CPU. A single state
// register steps through fetch, decode and execute phases; every control
// output is decoded combinationally from the current state, the instruction
// register contents and the zero flag.
//
// Ports
//    clk             sole clock, rising edge
//    rst             synchronous, active-high reset (returns to S_IDLE)
//    instruction     current IR contents: opcode[ws-1:ws-4], src[3:2], dest[1:0]
//    zero            ALU-result-zero flag, only consulted in S_DEC
//    Load_R0..R3     register file load enables (at most one per cycle)
//    Load_PC/Inc_PC  program counter load / increment (never both)
//    Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z   datapath register loads
//    Sel_Bus_1_Mux   0..3 = R0..R3, 4 = PC
//    Sel_Bus_2_Mux   0 = ALU, 1 = Bus_1, 2 = memory
//    write           memory write strobe
//    state           current state code, for debug and verification
// -----------------------------------------------------------------------------
module control_unit #(
   parameter int ws = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [ws-1:0] instruction,
   input  logic          zero,
   output logic          Load_R0,
   output logic          Load_R1,
   output logic          Load_R2,
   output logic          Load_R3,
   output logic          Load_PC,
   output logic          Inc_PC,
   output logic          Load_IR,
   output logic          Load_Add_R,
   output logic          Load_Reg_Y,
   output logic          Load_Reg_Z,
   output logic [2:0]    Sel_Bus_1_Mux,
   output logic [1:0]    Sel_Bus_2_Mux,
   output logic          write,
   output logic [3:0]    state
);

   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_FET1 = 4'd1,
      S_FET2 = 4'd2,
      S_DEC  = 4'd3,
      S_EX1  = 4'd4,
      S_RD1  = 4'd5,
      S_RD2  = 4'd6,
      S_WR1  = 4'd7,
      S_WR2  = 4'd8,
      S_BR1  = 4'd9,
      S_BR2  = 4'd10,
      S_HALT = 4'd11
   } state_t;

   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_ADD = 4'd1;
   localparam logic [3:0] OP_SUB = 4'd2;
   localparam logic [3:0] OP_AND = 4'd3;
   localparam logic [3:0] OP_NOT = 4'd4;
   localparam logic [3:0] OP_RD  = 4'd5;
   localparam logic [3:0] OP_WR  = 4'd6;
   localparam logic [3:0] OP_BR  = 4'd7;
   localparam logic [3:0] OP_BRZ = 4'd8;

   localparam logic [2:0] SEL1_PC  = 3'd4;
   localparam logic [1:0] SEL2_ALU = 2'd0;
   localparam logic [1:0] SEL2_B1  = 2'd1;
   localparam logic [1:0] SEL2_MEM = 2'd2;

   state_t state_q, state_d;

   logic [3:0] opcode;
   logic [1:0] src;
   logic [1:0] dest;
   logic [3:0] load_r;    // one-hot register file load vector
   logic [3:0] dest_hot;  // dest decoded to one-hot

   assign opcode   = instruction[ws-1:ws-4];
   assign src      = instruction[3:2];
   assign dest     = instruction[1:0];
   assign dest_hot = 4'b0001 << dest;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      load_r        = 4'b0000;
      Load_PC       = 1'b0;
      Inc_PC        = 1'b0;
      Load_IR       = 1'b0;
      Load_Add_R    = 1'b0;
      Load_Reg_Y    = 1'b0;
      Load_Reg_Z    = 1'b0;
      Sel_Bus_1_Mux = 3'd0;
      Sel_Bus_2_Mux = 2'd0;
      write         = 1'b0;

      case (state_q)
         S_IDLE: state_d = S_FET1;

         S_FET1: begin
            // Place PC into the address register
            Sel_Bus_1_Mux = SEL1_PC;
            Sel_Bus_2_Mux = SEL2_B1;
            Load_Add_R    = 1'b1;
            state_d       = S_FET2;
         end

         S_FET2: begin
            Sel_Bus_2_Mux = SEL2_MEM;
            Load_IR       = 1'b1;
            Inc_PC        = 1'b1;
            state_d       = S_DEC;
         end

         S_DEC: begin
            case (opcode)
               OP_NOP: state_d = S_FET1;
               OP_ADD, OP_SUB, OP_AND: begin
                  Sel_Bus_1_Mux = {1'b0, src};
                  Load_Reg_Y    = 1'b1;
                  state_d       = S_EX1;
               end
               OP_NOT: begin
                  // Unary op completes in decode: result goes straight back
                  Sel_Bus_1_Mux = {1'b0, src};
                  Sel_Bus_2_Mux = SEL2_ALU;
                  Load_Reg_Z    = 1'b1;
                  load_r        = dest_hot;
                  state_d       = S_FET1;
               end
               OP_RD, OP_WR, OP_BR, OP_BRZ: begin
                  if (opcode == OP_BRZ && !zero) begin
                     // Branch not taken: step PC over the address byte
                     Inc_PC  = 1'b1;
                     state_d = S_FET1;
                  end else begin
                     // Point the address register at the operand byte
                     Sel_Bus_1_Mux = SEL1_PC;
                     Sel_Bus_2_Mux = SEL2_B1;
                     Load_Add_R    = 1'b1;
                     case (opcode)
                        OP_RD:   state_d = S_RD1;
                        OP_WR:   state_d = S_WR1;
                        default: state_d = S_BR1;
                     endcase
                  end
               end
               default: state_d = S_HALT;
            endcase
         end

         S_EX1: begin
            Sel_Bus_1_Mux = {1'b0, dest};
            Sel_Bus_2_Mux = SEL2_ALU;
            Load_Reg_Z    = 1'b1;
            load_r        = dest_hot;
            state_d       = S_FET1;
         end

         S_RD1, S_WR1: begin
            // Operand byte becomes the data address
            Sel_Bus_2_Mux = SEL2_MEM;
            Load_Add_R    = 1'b1;
            Inc_PC        = 1'b1;
            state_d       = (state_q == S_RD1) ? S_RD2 : S_WR2;
         end

         S_RD2: begin
            Sel_Bus_2_Mux = SEL2_MEM;
            load_r        = dest_hot;
            state_d       = S_FET1;
         end

         S_WR2: begin
            Sel_Bus_1_Mux = {1'b0, src};
            write         = 1'b1;
            state_d       = S_FET1;
         end

         S_BR1: begin
            Sel_Bus_2_Mux = SEL2_MEM;
            Load_Add_R    = 1'b1;
            state_d       = S_BR2;
         end

         S_BR2: begin
            Sel_Bus_2_Mux = SEL2_MEM;
            Load_PC       = 1'b1;
            state_d       = S_FET1;
         end

         S_HALT: state_d = S_HALT;

         // Unused encodings recover to idle with all outputs quiet
         default: state_d = S_IDLE;
      endcase
   end

   assign Load_R0 = load_r[0];
   assign Load_R1 = load_r[1];
   assign Load_R2 = load_r[2];
   assign Load_R3 = load_r[3];
   assign state   = state_q;

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit
//
// Drives directed then random instruction streams into control_unit. For each
// instruction the reference model expands the whole expected per-cycle control
// sequence from the instruction-level behaviour table; each cycle's expected
// state and control word is pushed to a scoreboard queue and a separate
// monitor pops and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_control_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] instruction;
   logic       zero;
   logic       Load_R0, Load_R1, Load_R2, Load_R3;
   logic       Load_PC, Inc_PC, Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z;
   logic [2:0] Sel_Bus_1_Mux;
   logic [1:0] Sel_Bus_2_Mux;
   logic       write;
   logic [3:0] state;

   always #5 clk = ~clk;

   control_unit #(.ws(8)) dut (
      .clk(clk), .rst(rst), .instruction(instruction), .zero(zero),
      .Load_R0(Load_R0), .Load_R1(Load_R1), .Load_R2(Load_R2), .Load_R3(Load_R3),
      .Load_PC(Load_PC), .Inc_PC(Inc_PC), .Load_IR(Load_IR),
      .Load_Add_R(Load_Add_R), .Load_Reg_Y(Load_Reg_Y), .Load_Reg_Z(Load_Reg_Z),
      .Sel_Bus_1_Mux(Sel_Bus_1_Mux), .Sel_Bus_2_Mux(Sel_Bus_2_Mux),
      .write(write), .state(state)
   );

   typedef struct packed {
      logic [3:0] load_r;
      logic       load_pc, inc_pc, load_ir, load_add_r, load_reg_y, load_reg_z;
      logic [2:0] sel1;
      logic [1:0] sel2;
      logic       wr;
   } ctl_t;

   typedef struct packed {
      logic [3:0] st;
      ctl_t       ctl;
   } exp_t;

   typedef struct {
      logic [3:0] st;
      ctl_t       ctl;
      logic       zfixed;
      logic       zval;
   } step_t;

   step_t plan[$];
   exp_t  sb[$];
   int    checks = 0;
   int    errors = 0;

   logic [7:0] cur_instr;
   logic       halted;
   int         halt_cnt, halt_lim;
   logic       rst_at_wr1;

   // Directed prologue: {instruction, zero at decode, reset-in-WR1}
   logic [7:0] dir_instr [7] = '{8'h1B, 8'h51, 8'h80, 8'h80, 8'h62, 8'h47, 8'hF0};
   logic       dir_zero  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
   logic       dir_rstwr [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
   int         dir_idx = 0;

   function automatic ctl_t mk(input logic [2:0] s1, input logic [1:0] s2,
                               input logic [3:0] lr, input logic lpc, input logic ipc,
                               input logic lir, input logic lar, input logic ly,
                               input logic lz, input logic wr);
      ctl_t c;
      c            = '0;
      c.sel1       = s1;
      c.sel2       = s2;
      c.load_r     = lr;
      c.load_pc    = lpc;
      c.inc_pc     = ipc;
      c.load_ir    = lir;
      c.load_add_r = lar;
      c.load_reg_y = ly;
      c.load_reg_z = lz;
      c.wr         = wr;
      return c;
   endfunction

   task automatic add_step(input logic [3:0] st, input ctl_t c, input logic zf, input logic zv);
      step_t s;
      s.st = st; s.ctl = c; s.zfixed = zf; s.zval = zv;
      plan.push_back(s);
   endtask

   // Expand one instruction into its full cycle-by-cycle expected behaviour
   task automatic build_plan(input logic [7:0] ins, input logic z, input bit directed);
      logic [3:0] op;
      logic [2:0] src;
      logic [3:0] dhot;
      op   = ins[7:4];
      src  = {1'b0, ins[3:2]};
      dhot = 4'b0001 << ins[1:0];
      add_step(4'd1, mk(3'd4, 2'd1, 4'd0, 0, 0, 0, 1, 0, 0, 0), 0, 0);
      add_step(4'd2, mk(3'd0, 2'd2, 4'd0, 0, 1, 1, 0, 0, 0, 0), 0, 0);
      if (op == 0) begin
         add_step(4'd3, '0, 1, z);
      end else if (op >= 1 && op <= 3) begin
         add_step(4'd3, mk(src, 2'd0, 4'd0, 0, 0, 0, 0, 1, 0, 0), 1, z);
         add_step(4'd4, mk({1'b0, ins[1:0]}, 2'd0, dhot, 0, 0, 0, 0, 0, 1, 0), 0, 0);
      end else if (op == 4) begin
         add_step(4'd3, mk(src, 2'd0, dhot, 0, 0, 0, 0, 0, 1, 0), 1, z);
      end else if (op == 8 && !z) begin
         add_step(4'd3, mk(3'd0, 2'd0, 4'd0, 0, 1, 0, 0, 0, 0, 0), 1, z);
      end else if (op >= 5 && op <= 8) begin
         add_step(4'd3, mk(3'd4, 2'd1, 4'd0, 0, 0, 0, 1, 0, 0, 0), 1, z);
         if (op == 5) begin
            add_step(4'd5, mk(3'd0, 2'd2, 4'd0, 0, 1, 0, 1, 0, 0, 0), 0, 0);
            add_step(4'd6, mk(3'd0, 2'd2, dhot, 0, 0, 0, 0, 0, 0, 0), 0, 0);
         end else if (op == 6) begin
            add_step(4'd7, mk(3'd0, 2'd2, 4'd0, 0, 1, 0, 1, 0, 0, 0), 0, 0);
            add_step(4'd8, mk(src, 2'd0, 4'd0, 0, 0, 0, 0, 0, 0, 1), 0, 0);
         end else begin
            add_step(4'd9, mk(3'd0, 2'd2, 4'd0, 0, 0, 0, 1, 0, 0, 0), 0, 0);
            add_step(4'd10, mk(3'd0, 2'd2, 4'd0, 1, 0, 0, 0, 0, 0, 0), 0, 0);
         end
      end else begin
         add_step(4'd3, '0, 1, z);
         halted   = 1'b1;
         halt_cnt = 0;
         halt_lim = directed ? 10 : int'($urandom_range(3, 8));
      end
   endtask

   // Driver + reference model
   initial begin
      step_t      s;
      logic       r;
      logic [7:0] ins;
      logic       z;
      bit         directed;
      rst         = 1'b1;
      instruction = 8'h00;
      zero        = 1'b0;
      cur_instr   = 8'h00;
      halted      = 1'b0;
      halt_cnt    = 0;
      halt_lim    = 0;
      rst_at_wr1  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      add_step(4'd0, '0, 0, 0);
      for (int cyc = 0; cyc < 2000; cyc++) begin
         directed = (dir_idx < 7);
         if (plan.size() == 0) begin
            if (halted) begin
               add_step(4'd11, '0, 0, 0);
            end else begin
               if (directed) begin
                  ins        = dir_instr[dir_idx];
                  z          = dir_zero[dir_idx];
                  rst_at_wr1 = dir_rstwr[dir_idx];
                  dir_idx++;
               end else begin
                  ins[7:4] = ($urandom_range(0, 9) == 9) ? 4'($urandom_range(9, 15))
                                                         : 4'($urandom_range(0, 8));
                  ins[3:0] = 4'($urandom_range(0, 15));
                  z        = 1'($urandom_range(0, 1));
               end
               cur_instr = ins;
               $display("t=%0t instr=%02h zero=%0b", $time, ins, z);
               build_plan(ins, z, directed);
            end
         end
         s           = plan.pop_front();
         instruction = cur_instr;
         zero        = s.zfixed ? s.zval : 1'($urandom_range(0, 1));
         r           = 1'b0;
         if (halted && plan.size() == 0 && s.st == 4'd11) begin
            halt_cnt++;
            if (halt_cnt >= halt_lim) r = 1'b1;
         end else if (rst_at_wr1 && s.st == 4'd7) begin
            r          = 1'b1;
            rst_at_wr1 = 1'b0;
         end else if (!directed && $urandom_range(0, 99) < 2) begin
            r = 1'b1;
         end
         rst = r;
         sb.push_back({s.st, s.ctl});
         if (r) begin
            plan.delete();
            halted = 1'b0;
            add_step(4'd0, '0, 0, 0);
         end
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      for (int w = 0; w < 5 && sb.size() > 0; w++) @(posedge clk);
      if (sb.size() != 0) begin
         $display("FAIL drain: %0d expected entries never checked, required 0", sb.size());
         errors++;
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Monitor: compare DUT outputs with the oldest expected entry
   initial begin
      exp_t e;
      ctl_t act;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e              = sb.pop_front();
            act.load_r     = {Load_R3, Load_R2, Load_R1, Load_R0};
            act.load_pc    = Load_PC;
            act.inc_pc     = Inc_PC;
            act.load_ir    = Load_IR;
            act.load_add_r = Load_Add_R;
            act.load_reg_y = Load_Reg_Y;
            act.load_reg_z = Load_Reg_Z;
            act.sel1       = Sel_Bus_1_Mux;
            act.sel2       = Sel_Bus_2_Mux;
            act.wr         = write;
            checks++;
            if (state !== e.st) begin
               errors++;
               $display("FAIL state t=%0t actual=%0d required=%0d", $time, state, e.st);
            end
            checks++;
            if (act !== e.ctl) begin
               errors++;
               $display("FAIL ctl t=%0t state=%0d actual=%04h required=%04h",
                        $time, e.st, act, e.ctl);
            end
            checks++;
            if (Load_PC && Inc_PC) begin
               errors++;
               $display("FAIL pc_excl t=%0t Load_PC=%0b Inc_PC=%0b required not both",
                        $time, Load_PC, Inc_PC);
            end
            checks++;
            if ($countones(act.load_r) > 1) begin
               errors++;
               $display("FAIL load_r_onehot t=%0t actual=%04b required at most one",
                        $time, act.load_r);
            end
         end
      end
   end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter: ws, 8, word width; instruction fields are opcode = instruction[ws-1:ws-4], src = instruction[3:2], dest = instruction[1:0].
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 instruction  input  ws  current IR contents.
REQ-005 zero  input  1  Reg_Z flag (ALU result zero), sampled only in S_DEC.
REQ-006 Load_R0, Load_R1, Load_R2, Load_R3  output  1 each  register file load enables.
REQ-007 Load_PC  output  1; Inc_PC  output  1  program counter controls.
REQ-008 Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z  output  1 each  datapath register loads.
REQ-009 Sel_Bus_1_Mux  output  3  0=R0, 1=R1, 2=R2, 3=R3, 4=PC.
REQ-010 Sel_Bus_2_Mux  output  2  0=ALU, 1=Bus_1, 2=memory.
REQ-011 write  output  1  memory write strobe.
REQ-012 state  output  4  current FSM state code (debug/verification).

Function
REQ-013 Single registered state; all other outputs combinational from state, instruction and zero; any output not listed for a state is 0.
REQ-014 State codes: S_IDLE 0, S_FET1 1, S_FET2 2, S_DEC 3, S_EX1 4, S_RD1 5, S_RD2 6, S_WR1 7, S_WR2 8, S_BR1 9, S_BR2 10, S_HALT 11; codes 12-15 go to S_IDLE next cycle with all outputs 0.
REQ-015 Opcodes: NOP 0, ADD 1, SUB 2, AND 3, NOT 4, RD 5, WR 6, BR 7, BRZ 8; 9-15 treated as HALT.
REQ-016 S_IDLE: no outputs -> S_FET1.
REQ-017 S_FET1: Sel_Bus_1=PC, Sel_Bus_2=Bus_1, Load_Add_R -> S_FET2.
REQ-018 S_FET2: Sel_Bus_2=memory, Load_IR, Inc_PC -> S_DEC.
REQ-019 S_DEC NOP: no outputs -> S_FET1.
REQ-020 S_DEC ADD/SUB/AND: Sel_Bus_1=src, Load_Reg_Y -> S_EX1.
REQ-021 S_DEC NOT: Sel_Bus_1=src, Sel_Bus_2=ALU, Load_Reg_Z, Load_R[dest] -> S_FET1.
REQ-022 S_DEC RD/WR/BR, and BRZ with zero=1: Sel_Bus_1=PC, Sel_Bus_2=Bus_1, Load_Add_R -> S_RD1/S_WR1/S_BR1/S_BR1.
REQ-023 S_DEC BRZ with zero=0: Inc_PC only (skip address byte) -> S_FET1.
REQ-024 S_DEC HALT/illegal: no outputs -> S_HALT.
REQ-025 S_EX1: Sel_Bus_1=dest, Sel_Bus_2=ALU, Load_Reg_Z, Load_R[dest] -> S_FET1.
REQ-026 S_RD1 and S_WR1: Sel_Bus_2=memory, Load_Add_R, Inc_PC -> S_RD2 / S_WR2.
REQ-027 S_RD2: Sel_Bus_2=memory, Load_R[dest] -> S_FET1.
REQ-028 S_WR2: Sel_Bus_1=src, write -> S_FET1.
REQ-029 S_BR1: Sel_Bus_2=memory, Load_Add_R -> S_BR2.
REQ-030 S_BR2: Sel_Bus_2=memory, Load_PC -> S_FET1.
REQ-031 S_HALT: no outputs, remains until rst.
REQ-032 Load_PC and Inc_PC never both 1 in any cycle; at most one Load_Rn asserted per cycle.
REQ-033 Latencies from S_FET1 to next S_FET1: NOP 3, NOT 3, BRZ-not-taken 3, ALU ops 4, RD/WR/BR/BRZ-taken 5 cycles.

Reset
REQ-034 rst=1 at a rising edge forces state to S_IDLE regardless of current state, including mid-instruction and S_HALT; rst has priority over all transitions.
REQ-035 While in S_IDLE every control output is 0 and state=0; first fetch (S_FET1) begins the cycle after rst deasserts.

Verification
REQ-036 Reset release -> state sequence 0,1,2,3; Load_Add_R=1 with Sel_Bus_1=4 in state 1; Load_IR=1, Inc_PC=1 in state 2.
REQ-037 instruction=8'h1B (ADD src=R2 dest=R3) in S_DEC -> Load_Reg_Y with Sel_Bus_1=2, then S_EX1: Load_R3=1, Load_Reg_Z=1, Sel_Bus_1=3, Sel_Bus_2=0; back to S_FET1.
REQ-038 instruction=8'h51 (RD dest=R1) -> states 3,5,6,1; Inc_PC in S_RD1; Load_R1=1 with Sel_Bus_2=2 in S_RD2; write stays 0.
REQ-039 instruction=8'h80 with zero=0 -> Inc_PC=1 in S_DEC, next state 1; with zero=1 -> states 3,9,10,1 and Load_PC=1 in S_BR2.
REQ-040 instruction=8'hF0 -> S_HALT held 10 cycles with all outputs 0; rst pulse -> S_IDLE then S_FET1.
REQ-041 rst asserted in S_WR1 -> next state 0, write never asserted; every cycle of all tests checks !(Load_PC & Inc_PC).
